// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the SRAM arbiter slice: the arbiter FSM state
// encoding and the two round-robin preference values used by the top level
// and by the priority-pick sub-module.
// ---------------------------------------------------------------------------
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } arbState_e;

   localparam logic PREF_WR = 1'b0;
   localparam logic PREF_RD = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// ---------------------------------------------------------------------------
// sram_arb_pick
// Two-way priority pick between the write requester and the read requester.
// A lone request always wins; when both request together the side named by
// the preference input wins. The result is one-hot (or all zero).
//
// Ports
//   wr_req_i  : write requester is asking
//   rd_req_i  : read requester is asking
//   pref_i    : PREF_WR or PREF_RD, which side wins a collision
//   wr_gnt_o  : write side picked
//   rd_gnt_o  : read side picked
// ---------------------------------------------------------------------------
module sram_arb_pick (
   input  logic wr_req_i,
   input  logic rd_req_i,
   input  logic pref_i,
   output logic wr_gnt_o,
   output logic rd_gnt_o
);
   import sram_arb_pkg::*;

   // A side wins if it asks and either the other side is silent or the
   // preference points at it, so both outputs can never be high together.
   assign wr_gnt_o = wr_req_i & (~rd_req_i | (pref_i == PREF_WR));
   assign rd_gnt_o = rd_req_i & (~wr_req_i | (pref_i == PREF_RD));

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Arbitrates a single-word writer and a burst reader onto one synchronous
// SRAM. Arbitration only happens in IDLE; a write occupies one WR cycle and a
// read burst occupies L RD cycles. All SRAM pins are registered. Read data
// comes back from the SRAM one cycle after each access and is flagged with
// rd_valid / rd_last.
//
// Parameters
//   DATA_WIDTH    : SRAM word width
//   ADDRESS_WIDTH : SRAM address width, RAM depth is 2**ADDRESS_WIDTH
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   wr_req/wr_gnt   : write request, one-cycle combinational grant
//   wr_addr/wr_data : write address and data, held while wr_req is high
//   rd_req/rd_gnt   : read burst request, one-cycle combinational grant
//   rd_addr/rd_len  : burst start address and beat count
//   rd_data         : read beat data (pass-through of sram_data_out)
//   rd_valid/rd_last: beat valid and final-beat flag
//   busy            : FSM is not in IDLE
//   sram_*          : SRAM pins; sram_data_out is the SRAM read data
//
// Configuration macro
//   SRAM_ARB_FIXED_PRIO_EN : when defined the reader always wins collisions
//                            and there is no preference register; otherwise
//                            preference alternates after every grant.
// ---------------------------------------------------------------------------
module sram_arbiter #(
   parameter int DATA_WIDTH    = 16,
   parameter int ADDRESS_WIDTH = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_req,
   output logic                         wr_gnt,
   input  logic [ADDRESS_WIDTH-1:0]     wr_addr,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   input  logic                         rd_req,
   output logic                         rd_gnt,
   input  logic [ADDRESS_WIDTH-1:0]     rd_addr,
   input  logic [ADDRESS_WIDTH:0]       rd_len,
   output logic signed [DATA_WIDTH-1:0] rd_data,
   output logic                         rd_valid,
   output logic                         rd_last,
   output logic                         busy,
   output logic [ADDRESS_WIDTH-1:0]     sram_address,
   output logic                         sram_chip_sel,
   output logic                         sram_write_en,
   output logic                         sram_out_en,
   output logic signed [DATA_WIDTH-1:0] sram_data_in,
   input  logic signed [DATA_WIDTH-1:0] sram_data_out
);
   import sram_arb_pkg::*;

   localparam int LEN_W     = ADDRESS_WIDTH + 1;
   localparam int RAM_DEPTH = 1 << ADDRESS_WIDTH;
   localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(RAM_DEPTH);

   arbState_e                     state_q;
   logic [LEN_W-1:0]              burstCount_q;
   logic [LEN_W-1:0]              burstCount_d;
   logic [ADDRESS_WIDTH-1:0]      sramAddress_q;
   logic signed [DATA_WIDTH-1:0]  sramDataIn_q;
   logic                          chipSel_q;
   logic                          writeEn_q;
   logic                          outEn_q;
   logic                          rdValid_q;
   logic                          rdLast_q;
   logic                          prefSel;
   logic                          pickWr;
   logic                          pickRd;

   sram_arb_pick uPick (
      .wr_req_i (wr_req),
      .rd_req_i (rd_req),
      .pref_i   (prefSel),
      .wr_gnt_o (pickWr),
      .rd_gnt_o (pickRd)
   );

   // Grants are only offered from IDLE and never while reset is held, so a
   // requester that arrives mid-transaction simply keeps waiting.
   assign wr_gnt = (state_q == IDLE) && !rst && pickWr;
   assign rd_gnt = (state_q == IDLE) && !rst && pickRd;

   // The burst counter holds "beats remaining after the current one", so the
   // value loaded on a read grant is the effective length minus one. A zero
   // length still reads one word and anything longer than the RAM is clipped
   // to one full pass over it.
   always_comb begin
      burstCount_d = '0;
      if (rd_len == '0) begin
         burstCount_d = '0;
      end else if (rd_len > DEPTH_LEN) begin
         burstCount_d = DEPTH_LEN - LEN_W'(1);
      end else begin
         burstCount_d = rd_len - LEN_W'(1);
      end
   end

`ifdef SRAM_ARB_FIXED_PRIO_EN
   // Reader always wins collisions, so no history needs to be kept.
   assign prefSel = PREF_RD;
`else
   logic prefQ;

   // Round-robin history: whichever side was just served loses the next
   // collision. Reset favours the writer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prefQ <= PREF_WR;
      end else if (wr_gnt) begin
         prefQ <= PREF_RD;
      end else if (rd_gnt) begin
         prefQ <= PREF_WR;
      end
   end

   assign prefSel = prefQ;
`endif

   // Main FSM with all SRAM pins and the read-beat flags registered here.
   // rd_valid/rd_last are a one-stage delay of "an RD access happened last
   // cycle", matching the SRAM's one-cycle read latency. On leaving RD or WR
   // the strobes drop but address and write data keep their last values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         burstCount_q  <= '0;
         sramAddress_q <= '0;
         sramDataIn_q  <= '0;
         chipSel_q     <= 1'b0;
         writeEn_q     <= 1'b0;
         outEn_q       <= 1'b0;
         rdValid_q     <= 1'b0;
         rdLast_q      <= 1'b0;
      end else begin
         rdValid_q <= (state_q == RD);
         rdLast_q  <= (state_q == RD) && (burstCount_q == '0);
         case (state_q)
            IDLE: begin
               if (wr_gnt) begin
                  state_q       <= WR;
                  sramAddress_q <= wr_addr;
                  sramDataIn_q  <= wr_data;
                  chipSel_q     <= 1'b1;
                  writeEn_q     <= 1'b1;
                  outEn_q       <= 1'b0;
               end else if (rd_gnt) begin
                  state_q       <= RD;
                  sramAddress_q <= rd_addr;
                  burstCount_q  <= burstCount_d;
                  chipSel_q     <= 1'b1;
                  writeEn_q     <= 1'b0;
                  outEn_q       <= 1'b1;
               end
            end
            WR: begin
               state_q   <= IDLE;
               chipSel_q <= 1'b0;
               writeEn_q <= 1'b0;
               outEn_q   <= 1'b0;
            end
            RD: begin
               if (burstCount_q == '0) begin
                  state_q   <= IDLE;
                  chipSel_q <= 1'b0;
                  writeEn_q <= 1'b0;
                  outEn_q   <= 1'b0;
               end else begin
                  burstCount_q  <= burstCount_q - LEN_W'(1);
                  sramAddress_q <= sramAddress_q + ADDRESS_WIDTH'(1);
               end
            end
            default: begin
               state_q   <= IDLE;
               chipSel_q <= 1'b0;
               writeEn_q <= 1'b0;
               outEn_q   <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = (state_q != IDLE);
   assign sram_address  = sramAddress_q;
   assign sram_chip_sel = chipSel_q;
   assign sram_write_en = writeEn_q;
   assign sram_out_en   = outEn_q;
   assign sram_data_in  = sramDataIn_q;
   assign rd_valid      = rdValid_q;
   assign rd_last       = rdLast_q;
   assign rd_data       = sram_data_out;

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter. The bench owns a synchronous SRAM
// model wired to the arbiter's pins. A reference model predicts grants from
// the request lines and a simple "arbiter free at cycle N" timeline, and
// pushes the expected SRAM accesses and read beats into queues; a separate
// scoreboard pops and compares them whenever the DUT presents an access or
// a beat. Honours SRAM_ARB_FIXED_PRIO_EN like the design.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED_PRIO = 1'b1;
`else
   localparam bit FIXED_PRIO = 1'b0;
`endif

   localparam int DEPTH = 8;

   typedef struct {
      int                 cyc;
      logic signed [15:0] data;
      logic               last;
   } beat_t;

   typedef struct {
      int                 cyc;
      logic               isWr;
      logic [2:0]         addr;
      logic signed [15:0] data;
   } access_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               wr_req = 1'b0;
   logic               rd_req = 1'b0;
   logic [2:0]         wr_addr = '0;
   logic signed [15:0] wr_data = '0;
   logic [2:0]         rd_addr = '0;
   logic [3:0]         rd_len = '0;
   logic               wr_gnt, rd_gnt, rd_valid, rd_last, busy;
   logic signed [15:0] rd_data;
   logic [2:0]         sram_address;
   logic               sram_chip_sel, sram_write_en, sram_out_en;
   logic signed [15:0] sram_data_in;
   logic signed [15:0] sram_data_out;

   logic signed [15:0] sramMem [DEPTH];
   logic signed [15:0] refMem [DEPTH];
   beat_t              beatQ[$];
   access_t            accessQ[$];
   logic signed [15:0] captured[$];

   int cycleCount = 0;
   int nextIdle = 0;
   bit prefRead = 1'b0;
   int assertCount = 0;
   int failCount = 0;
   int validSeen = 0;
   int lastWrGnt = 0;
   int lastRdGnt = 0;
   logic wrGntSawLast = 1'b0;
   int orderBits = 0;

   sram_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_req        (wr_req),
      .wr_gnt        (wr_gnt),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .rd_req        (rd_req),
      .rd_gnt        (rd_gnt),
      .rd_addr       (rd_addr),
      .rd_len        (rd_len),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .rd_last       (rd_last),
      .busy          (busy),
      .sram_address  (sram_address),
      .sram_chip_sel (sram_chip_sel),
      .sram_write_en (sram_write_en),
      .sram_out_en   (sram_out_en),
      .sram_data_in  (sram_data_in),
      .sram_data_out (sram_data_out)
   );

   always #5 clk = ~clk;

   // Cycle numbering: a cycle starts at a rising edge and is sampled at the
   // following falling edge.
   always @(posedge clk) cycleCount++;

   // Synchronous single-port SRAM: writes land and read data appears at the
   // rising edge that ends the access cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sram_data_out <= '0;
      end else if (sram_chip_sel) begin
         if (sram_write_en) begin
            sramMem[sram_address] <= sram_data_in;
         end else if (sram_out_en) begin
            sram_data_out <= sramMem[sram_address];
         end
      end
   end

   task automatic checkOutput(input string name, input logic signed [63:0] actual,
                              input logic signed [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   // Reference model: the arbiter is free from cycle nextIdle onwards. A
   // write occupies the next cycle, a read occupies the next L cycles and
   // returns its beats one cycle after each access.
   always @(negedge clk) begin : refModel
      logic    expWr;
      logic    expRd;
      int      effLen;
      int      idx;
      beat_t   b;
      access_t a;
      if (rst) begin
         nextIdle = 0;
         prefRead = 1'b0;
         beatQ.delete();
         accessQ.delete();
         checkOutput("wr_gnt in reset", wr_gnt, 0);
         checkOutput("rd_gnt in reset", rd_gnt, 0);
         checkOutput("busy in reset", busy, 0);
         checkOutput("rd_valid in reset", rd_valid, 0);
         checkOutput("chip_sel in reset", sram_chip_sel, 0);
      end else begin
         checkOutput("busy", busy, (cycleCount < nextIdle) ? 1 : 0);
         expWr = 1'b0;
         expRd = 1'b0;
         if (cycleCount >= nextIdle) begin
            if (wr_req && rd_req) begin
               expRd = FIXED_PRIO ? 1'b1 : prefRead;
               expWr = !expRd;
            end else begin
               expWr = wr_req;
               expRd = rd_req;
            end
         end
         checkOutput("wr_gnt", wr_gnt, expWr);
         checkOutput("rd_gnt", rd_gnt, expRd);
         if (expWr) begin
            a.cyc  = cycleCount + 1;
            a.isWr = 1'b1;
            a.addr = wr_addr;
            a.data = wr_data;
            accessQ.push_back(a);
            refMem[wr_addr] = wr_data;
            nextIdle = cycleCount + 2;
            prefRead = 1'b1;
         end
         if (expRd) begin
            if (rd_len == 0) effLen = 1;
            else if (int'(rd_len) > DEPTH) effLen = DEPTH;
            else effLen = int'(rd_len);
            for (int k = 0; k < effLen; k++) begin
               idx    = (int'(rd_addr) + k) % DEPTH;
               a.cyc  = cycleCount + 1 + k;
               a.isWr = 1'b0;
               a.addr = 3'(idx);
               a.data = '0;
               accessQ.push_back(a);
               b.cyc  = cycleCount + 2 + k;
               b.data = refMem[idx];
               b.last = (k == effLen - 1);
               beatQ.push_back(b);
            end
            nextIdle = cycleCount + 1 + effLen;
            prefRead = 1'b0;
         end
      end
   end

   // Scoreboard: pops an expectation whenever the DUT shows a beat or an
   // SRAM access, and flags expectations whose cycle has passed unserved.
   always @(negedge clk) begin : scoreboard
      beat_t   b;
      access_t a;
      if (!rst) begin
         if (rd_valid) begin
            validSeen++;
            captured.push_back(rd_data);
            if (beatQ.size() == 0) begin
               checkOutput("rd_valid unexpected", rd_valid, 0);
            end else begin
               b = beatQ.pop_front();
               checkOutput("beat cycle", cycleCount, b.cyc);
               checkOutput("rd_data", rd_data, b.data);
               checkOutput("rd_last", rd_last, b.last);
            end
         end else begin
            checkOutput("rd_last without rd_valid", rd_last, 0);
            if (beatQ.size() > 0 && beatQ[0].cyc <= cycleCount) begin
               b = beatQ.pop_front();
               checkOutput("rd_valid missing", rd_valid, 1);
            end
         end
         if (sram_chip_sel) begin
            if (accessQ.size() == 0) begin
               checkOutput("sram access unexpected", sram_chip_sel, 0);
            end else begin
               a = accessQ.pop_front();
               checkOutput("sram access cycle", cycleCount, a.cyc);
               checkOutput("sram_write_en", sram_write_en, a.isWr);
               checkOutput("sram_out_en", sram_out_en, !a.isWr);
               checkOutput("sram_address", sram_address, a.addr);
               if (a.isWr) checkOutput("sram_data_in", sram_data_in, a.data);
            end
         end else begin
            checkOutput("sram_write_en idle", sram_write_en, 0);
            checkOutput("sram_out_en idle", sram_out_en, 0);
            if (accessQ.size() > 0 && accessQ[0].cyc <= cycleCount) begin
               a = accessQ.pop_front();
               checkOutput("sram access missing", sram_chip_sel, 1);
            end
         end
      end
   end

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs();
      checkOutput("rst wr_gnt", wr_gnt, 0);
      checkOutput("rst rd_gnt", rd_gnt, 0);
      checkOutput("rst rd_valid", rd_valid, 0);
      checkOutput("rst rd_last", rd_last, 0);
      checkOutput("rst busy", busy, 0);
      checkOutput("rst sram_address", sram_address, 0);
      checkOutput("rst sram_chip_sel", sram_chip_sel, 0);
      checkOutput("rst sram_write_en", sram_write_en, 0);
      checkOutput("rst sram_out_en", sram_out_en, 0);
      checkOutput("rst sram_data_in", sram_data_in, 0);
   endtask

   task automatic applyReset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkResetOutputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic doWrite(input int a, input int d);
      int waited = 0;
      wr_addr = 3'(a);
      wr_data = 16'(d);
      wr_req  = 1'b1;
      do begin
         @(negedge clk);
         waited++;
      end while (!wr_gnt && waited < 300);
      if (wr_gnt) begin
         lastWrGnt    = cycleCount;
         wrGntSawLast = rd_last;
         orderBits    = orderBits << 1;
      end else begin
         checkOutput("wr_gnt within bound", wr_gnt, 1);
      end
      @(posedge clk);
      #1;
      wr_req = 1'b0;
   endtask

   task automatic doRead(input int a, input int len);
      int waited = 0;
      rd_addr = 3'(a);
      rd_len  = 4'(len);
      rd_req  = 1'b1;
      do begin
         @(negedge clk);
         waited++;
      end while (!rd_gnt && waited < 300);
      if (rd_gnt) begin
         lastRdGnt = cycleCount;
         orderBits = (orderBits << 1) | 1;
      end else begin
         checkOutput("rd_gnt within bound", rd_gnt, 1);
      end
      @(posedge clk);
      #1;
      rd_req = 1'b0;
   endtask

   task automatic applyStimulus();
      int base;
      int waited;
      int expBurst[4] = '{16, 17, 10, 11};

      applyReset();

      doWrite(5, -7);
      idleCycles(2);
      captured.delete();
      doRead(5, 1);
      idleCycles(4);
      checkOutput("addr5 beat count", captured.size(), 1);
      if (captured.size() >= 1) checkOutput("addr5 readback", captured[0], -7);

      for (int i = 0; i < DEPTH; i++) doWrite(i, 10 + i);
      idleCycles(2);
      captured.delete();
      doRead(6, 4);
      idleCycles(8);
      checkOutput("wrap burst beat count", captured.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < captured.size()) checkOutput("wrap burst data", captured[i], expBurst[i]);
      end

      base = validSeen;
      doRead(3, 0);
      idleCycles(4);
      checkOutput("rd_len 0 beats", validSeen - base, 1);
      base = validSeen;
      doRead(2, 15);
      idleCycles(12);
      checkOutput("rd_len 15 beats", validSeen - base, 8);

      applyReset();
      orderBits = 0;
      fork
         begin
            doWrite(1, 100);
            doWrite(2, 200);
            doWrite(3, 300);
         end
         begin
            doRead(1, 1);
            doRead(2, 1);
            doRead(3, 1);
         end
      join
      idleCycles(4);
      checkOutput("collision grant order", orderBits, FIXED_PRIO ? 56 : 21);

      fork
         doRead(0, 8);
         begin
            repeat (3) @(posedge clk);
            #1;
            doWrite(4, 44);
         end
      join
      checkOutput("wr_gnt after burst", lastWrGnt, lastRdGnt + 9);
      checkOutput("wr_gnt overlaps rd_last", wrGntSawLast, 1);
      idleCycles(4);

      base = validSeen;
      fork
         doRead(0, 8);
         begin
            waited = 0;
            while (validSeen < base + 2 && waited < 50) begin
               @(negedge clk);
               #1;
               waited++;
            end
            checkOutput("reached beat 2", validSeen - base, 2);
            rst = 1'b1;
            #1;
            checkResetOutputs();
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            @(posedge clk);
            #1;
         end
      join
      idleCycles(12);
      checkOutput("beats after mid-burst reset", validSeen - base, 2);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: doWrite($urandom_range(0, 7), $urandom_range(0, 65535));
            1: doRead($urandom_range(0, 7), $urandom_range(0, 15));
            default: begin
               fork
                  doWrite($urandom_range(0, 7), $urandom_range(0, 65535));
                  doRead($urandom_range(0, 7), $urandom_range(0, 15));
               join
            end
         endcase
         idleCycles($urandom_range(1, 3));
      end
   endtask

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int waited;
      for (int i = 0; i < DEPTH; i++) begin
         sramMem[i] = '0;
         refMem[i]  = '0;
      end
      applyStimulus();
      waited = 0;
      while ((beatQ.size() + accessQ.size()) > 0 && waited < 40) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput("scoreboard drained", beatQ.size() + accessQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the SRAM word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 3, the SRAM address width; RAM_DEPTH = 2^ADDRESS_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port wr_req/wr_gnt, input/output, 1 bit each: write-requester request and one-cycle grant.
REQ-006 SHALL have port wr_addr/wr_data, inputs, ADDRESS_WIDTH/DATA_WIDTH signed: write address and data, stable while wr_req is high.
REQ-007 SHALL have port rd_req/rd_gnt, input/output, 1 bit each: read-burst request and one-cycle grant.
REQ-008 SHALL have port rd_addr/rd_len, inputs, ADDRESS_WIDTH/ADDRESS_WIDTH+1: burst start address and beat count, stable while rd_req is high.
REQ-009 SHALL have port rd_data, output, DATA_WIDTH signed: read beat data, equal to sram_data_out.
REQ-010 SHALL have port rd_valid/rd_last, outputs, 1 bit each: beat valid and final-beat flag.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-012 SHALL have ports sram_address, sram_chip_sel, sram_write_en, sram_out_en, sram_data_in, outputs, driving the SRAM pins of the same names; sram_data_out, input, DATA_WIDTH signed.

Function
REQ-013 SHALL implement FSM states IDLE, WR, RD; the SRAM-side outputs SHALL be registered.
REQ-014 SHALL arbitrate in IDLE only; a request arriving outside IDLE SHALL wait, and requesters hold req until gnt.
REQ-015 SHALL, in IDLE, grant the requester alone present, or the preferred one when both are present; gnt is combinational and high for exactly that cycle T.
REQ-016 SHALL, on a write grant in cycle T, capture wr_addr/wr_data, enter WR for cycle T+1 with chip_sel=1, write_en=1, out_en=0, then return to IDLE (one write per 2 cycles).
REQ-017 SHALL, on a read grant in cycle T, capture rd_addr and the effective length L, then stay in RD for cycles T+1..T+L with chip_sel=1, write_en=0, out_en=1.
REQ-018 SHALL compute L as: rd_len=0 -> 1; rd_len>RAM_DEPTH -> RAM_DEPTH; otherwise rd_len.
REQ-019 SHALL present address rd_addr+k in RD cycle T+1+k, wrapping modulo RAM_DEPTH.
REQ-020 SHALL assert rd_valid in cycles T+2..T+L+1, one cycle after each read access, and rd_last with the final rd_valid only.
REQ-021 SHALL return to IDLE after the L-th RD cycle; arbitration resumes in that IDLE cycle, overlapping the last rd_valid.
REQ-022 SHALL use round-robin preference: after a write grant the reader is preferred; after a read grant the writer is preferred.
REQ-023 SHALL drive chip_sel, write_en and out_en to 0 in IDLE; address and data hold their last values.

Reset
REQ-024 SHALL, on rst high, immediately force IDLE, writer preferred, all outputs 0, the rd_valid pipeline cleared, and the burst counter zeroed.
REQ-025 SHALL abandon a burst or write interrupted by reset; no rd_valid/rd_last occurs after reset, and the first grant follows the first clock edge with rst low.

Configuration
REQ-026 SHALL support macro SRAM_ARB_FIXED_PRIO_EN: when defined, the reader always wins simultaneous requests and the preference register is removed; when undefined, REQ-022 applies.

Structure
REQ-027 SHALL place the FSM state encodings (IDLE=0, WR=1, RD=2) and the PREF_WR/PREF_RD constants in shared package sram_arb_pkg.
REQ-028 SHALL use one sub-module, sram_arb_pick, for the two-way priority pick (req pair + preference -> one-hot grant); the SRAM itself is instantiated by the parent.

Verification
REQ-029 SHALL cover: wr_req with addr=5, data=-7 -> wr_gnt at T, sram write at T+1; a subsequent 1-beat read of addr 5 returns -7 with rd_valid and rd_last.
REQ-030 SHALL cover: rd_addr=6, rd_len=4 after preloading 0..7 with 10..17 -> addresses 6,7,0,1; rd_data 16,17,10,11; rd_last on 11.
REQ-031 SHALL cover: wr_req and rd_req together out of reset -> write first, then read; repeated collisions alternate; with SRAM_ARB_FIXED_PRIO_EN, read always first.
REQ-032 SHALL cover: rd_len=0 -> exactly 1 beat; rd_len=15 with ADDRESS_WIDTH=3 -> exactly 8 beats.
REQ-033 SHALL cover: rst pulsed during beat 2 of an 8-beat burst -> all outputs 0 at once, no further rd_valid, busy=0.
REQ-034 SHALL cover: wr_req asserted mid-burst -> no wr_gnt until the IDLE cycle after the burst, overlapping the last rd_valid.
